// File: rtl/alu_exec_pkg.sv
// Shared types and decode for the execute-stage ALU/MDU controller.
// Optional divider: define ALU_EXEC_DIV_EN to build DIV/DIVU/REM/REMU.
package alu_exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD     = 5'b00000,
    OP_SUB     = 5'b00001,
    OP_XOR     = 5'b00010,
    OP_OR      = 5'b00011,
    OP_AND     = 5'b00100,
    OP_SRL     = 5'b00101,
    OP_SLL     = 5'b00110,
    OP_SRA     = 5'b00111,
    OP_SLT     = 5'b01000,
    OP_SLTU    = 5'b01001,
    OP_BEQ     = 5'b01010,
    OP_PASSB   = 5'b01011,
    OP_MUL     = 5'b10000,
    OP_MULH    = 5'b10001,
    OP_MULHSU  = 5'b10010,
    OP_MULHU   = 5'b10011,
    OP_DIV     = 5'b10100,
    OP_DIVU    = 5'b10101,
    OP_REM     = 5'b10110,
    OP_REMU    = 5'b10111,
    OP_ILLEGAL = 5'b11111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    RESP
  } alu_state_e;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_JAL = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic alu_op_e alu_decode(
    input logic [1:0] aluop,
    input logic [6:0] f7,
    input logic [2:0] f3
  );
    alu_op_e op;
    op = OP_ILLEGAL;
    unique case (1'b1)
      aluop == ALUOP_MEM: op = OP_ADD;
      aluop == ALUOP_BR:  op = OP_BEQ;
      aluop == ALUOP_JAL: op = OP_PASSB;
      aluop == ALUOP_R && f7 == F7_BASE: begin
        unique case (f3)
          3'b000:  op = OP_ADD;
          3'b100:  op = OP_XOR;
          3'b110:  op = OP_OR;
          3'b111:  op = OP_AND;
          3'b101:  op = OP_SRL;
          3'b001:  op = OP_SLL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          default: op = OP_ILLEGAL;
        endcase
      end
      aluop == ALUOP_R && f7 == F7_ALT: begin
        unique case (f3)
          3'b000:  op = OP_SUB;
          3'b101:  op = OP_SRA;
          default: op = OP_ILLEGAL;
        endcase
      end
      aluop == ALUOP_R && f7 == F7_MULDIV: begin
`ifdef ALU_EXEC_DIV_EN
        op = alu_op_e'({2'b10, f3});
`else
        op = f3[2] ? OP_ILLEGAL : alu_op_e'({2'b10, f3});
`endif
      end
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_mdu_iter.sv
// Iterative shift-add multiplier and restoring divider on magnitudes.
// Divider datapath present only when ALU_EXEC_DIV_EN is defined.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [1:0]       fn_q, fn_d;

  logic             div_start;
  logic             a_sgn, b_sgn, sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_s;

`ifdef ALU_EXEC_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] quo, rem;
  assign div_start = func_i[2];
`else
  logic unused_func;
  assign unused_func = func_i[2];
  assign div_start   = 1'b0;
`endif

  // Signedness per variant: only MULHU/DIVU/REMU treat A as unsigned.
  always_comb begin
    a_sgn = div_start ? !func_i[0] : (func_i[1:0] != 2'b11);
    b_sgn = div_start ? !func_i[0] : !func_i[1];
    sa    = a_sgn & a_i[WIDTH-1];
    sb    = b_sgn & b_i[WIDTH-1];
    ma    = sa ? -a_i : a_i;
    mb    = sb ? -b_i : b_i;
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH-1));

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_EXEC_DIV_EN
    shl = {hi_q, lo_q[WIDTH-1]};
    if (div_q) begin
      if (shl >= {1'b0, opnd_q}) begin
        step_hi = WIDTH'(shl - {1'b0, opnd_q});
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shl[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Result is formed from the final step so it lands on the done cycle.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_s   = (sa_q ^ sb_q) ? -prod : prod;
    result_o = (fn_q == 2'b00) ? prod_s[WIDTH-1:0]
                               : prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_EXEC_DIV_EN
    quo = (sa_q ^ sb_q) ? -step_lo : step_lo;
    rem = sa_q ? -step_hi : step_hi;
    if (div_q) result_o = fn_q[1] ? rem : quo;
`endif
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    fn_d   = fn_q;
`ifdef ALU_EXEC_DIV_EN
    div_d  = div_q;
`endif
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      sa_d   = sa;
      sb_d   = sb;
      fn_d   = func_i[1:0];
      hi_d   = '0;
      lo_d   = div_start ? ma : mb;
      opnd_d = div_start ? mb : ma;
`ifdef ALU_EXEC_DIV_EN
      div_d  = div_start;
`endif
    end else if (busy_q) begin
      busy_d = !done_o;
      cnt_d  = cnt_q + CW'(1);
      hi_d   = step_hi;
      lo_d   = step_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      fn_q   <= '0;
`ifdef ALU_EXEC_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      fn_q   <= fn_d;
`ifdef ALU_EXEC_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage ALU controller: decode, base ALU, MDU sequencing.
// Define ALU_EXEC_DIV_EN to include the iterative divider.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       Operation,
  output logic             Illegal
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_op_e          op_q, op_d;
  logic             ill_q, ill_d;

  alu_op_e          dec_op;
  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    shamt;
  logic             is_mul;
  logic             mdu_start;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_res;

`ifdef ALU_EXEC_DIV_EN
  logic             is_div, div_zero, div_ovf;
  logic [WIDTH-1:0] bnd_res;
`endif

  assign dec_op = alu_decode(ALUOp, Funct7, Funct3);
  assign shamt  = SrcB[SW-1:0];
  assign is_mul = dec_op[4:2] == 3'b100;

  always_comb begin
    alu_res = '0;
    unique case (dec_op)
      OP_ADD:   alu_res = SrcA + SrcB;
      OP_SUB:   alu_res = SrcA - SrcB;
      OP_XOR:   alu_res = SrcA ^ SrcB;
      OP_OR:    alu_res = SrcA | SrcB;
      OP_AND:   alu_res = SrcA & SrcB;
      OP_SRL:   alu_res = SrcA >> shamt;
      OP_SLL:   alu_res = SrcA << shamt;
      OP_SRA:   alu_res = $signed(SrcA) >>> shamt;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      OP_BEQ:   alu_res = {{(WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_PASSB: alu_res = SrcB;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_DIV_EN
  // Corner cases answered directly; the iterative path never sees them.
  always_comb begin
    is_div   = dec_op[4:2] == 3'b101;
    div_zero = SrcB == '0;
    div_ovf  = !dec_op[0] && (SrcB == '1) &&
               (SrcA == {1'b1, {(WIDTH-1){1'b0}}});
    if (div_zero) bnd_res = dec_op[1] ? SrcA : '1;
    else          bnd_res = dec_op[1] ? '0 : SrcA;
  end
`endif

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    op_d      = op_q;
    ill_d     = ill_q;
    mdu_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = dec_op;
          ill_d   = dec_op == OP_ILLEGAL;
          res_d   = alu_res;
          state_d = RESP;
          if (is_mul) begin
            res_d     = res_q;
            mdu_start = 1'b1;
            state_d   = MUL;
          end
`ifdef ALU_EXEC_DIV_EN
          else if (is_div) begin
            if (div_zero || div_ovf) begin
              res_d = bnd_res;
            end else begin
              res_d     = res_q;
              mdu_start = 1'b1;
              state_d   = DIV;
            end
          end
`endif
        end
      end
      MUL, DIV: begin
        if (mdu_done) begin
          res_d   = mdu_res;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      op_q    <= OP_ADD;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mdu_start),
    .func_i  (dec_op[2:0]),
    .a_i     (SrcA),
    .b_i     (SrcB),
    .done_o  (mdu_done),
    .result_o(mdu_res)
  );

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = state_q == RESP;
  assign Result    = res_q;
  assign Operation = op_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a reference model.
// Honours ALU_EXEC_DIV_EN the same way as the design.
module tb_alu_exec_ctrl;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    ALUOp;
  logic [6:0]    Funct7;
  logic [2:0]    Funct3;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic [4:0]    Operation;
  logic          Illegal;

  alu_exec_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUOp    (ALUOp),
    .Funct7   (Funct7),
    .Funct3   (Funct3),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .Operation(Operation),
    .Illegal  (Illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  op;
    logic        ill;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  bit   mon_en = 0;
  bit   stall  = 0;
  bit   rnd_bp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] aluop,
                                 input logic [6:0] f7,
                                 input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, ua;
    logic [63:0] p;
    logic [31:0] q, r;
    int          sh;
    bit          bad;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = longint'({32'h0, a});
    sh  = int'(b[4:0]);
    bad = 0;
    e.res = 0; e.op = 0; e.ill = 0; e.lat = 1; e.acc = 0; e.seen = 0;
    if (aluop == 2'b00) begin
      e.op = 5'b00000; e.res = a + b;
    end else if (aluop == 2'b01) begin
      e.op = 5'b01010; e.res = {31'b0, a == b};
    end else if (aluop == 2'b11) begin
      e.op = 5'b01011; e.res = b;
    end else if (f7 == 7'h00) begin
      case (f3)
        3'd0: begin e.op = 5'b00000; e.res = a + b; end
        3'd4: begin e.op = 5'b00010; e.res = a ^ b; end
        3'd6: begin e.op = 5'b00011; e.res = a | b; end
        3'd7: begin e.op = 5'b00100; e.res = a & b; end
        3'd5: begin e.op = 5'b00101; e.res = a >> sh; end
        3'd1: begin e.op = 5'b00110; e.res = a << sh; end
        3'd2: begin e.op = 5'b01000; e.res = {31'b0, sa < sb}; end
        default: begin e.op = 5'b01001; e.res = {31'b0, a < b}; end
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) begin
      e.op = 5'b00001; e.res = a - b;
    end else if (f7 == 7'h20 && f3 == 3'd5) begin
      e.op = 5'b00111; e.res = $signed(a) >>> sh;
    end else if (f7 == 7'h01 && !f3[2]) begin
      e.op  = {2'b10, f3};
      e.lat = 33;
      case (f3[1:0])
        2'd0: p = sa * sb;
        2'd1: p = sa * sb;
        2'd2: p = sa * longint'({32'h0, b});
        default: p = {32'h0, a} * {32'h0, b};
      endcase
      e.res = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
    end else if (f7 == 7'h01) begin
`ifdef ALU_EXEC_DIV_EN
      e.op = {2'b10, f3};
      if (b == 0) begin
        q = '1; r = a;
      end else if (!f3[0] && a == 32'h8000_0000 && b == '1) begin
        q = a; r = 0;
      end else begin
        e.lat = 33;
        if (!f3[0]) begin
          q = 32'(sa / sb); r = 32'(sa % sb);
        end else begin
          q = a / b; r = a % b;
        end
      end
      e.res = f3[1] ? r : q;
`else
      bad = 1;
`endif
    end else begin
      bad = 1;
    end
    if (bad) begin
      e.op = 5'b11111; e.ill = 1; e.res = 0; e.lat = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_out: got result %h expected none", Result);
        end else begin
          chk("Result", Result, sbq[0].res);
          chk("Operation", {27'b0, Operation}, {27'b0, sbq[0].op});
          chk("Illegal", {31'b0, Illegal}, {31'b0, sbq[0].ill});
          chk("in_ready_in_resp", {31'b0, in_ready}, 32'd0);
          if (!sbq[0].seen) begin
            chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
            sbq[0].seen = 1;
          end
        end
      end
      out_ready = stall ? 1'b0 : (rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
    end
  end

  task automatic issue(input logic [1:0] aluop, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    ALUOp = aluop; Funct7 = f7; Funct3 = f3; SrcA = a; SrcB = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vecs++; errs++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    e     = model(aluop, f7, f3, a, b);
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    SrcA = $urandom; SrcB = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      vecs++; errs++;
      $display("FAIL response_timeout: got out_valid 0 expected 1");
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      vecs++; errs++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin
    logic [6:0] f7r;
    int         n;
    rst_n = 0; in_valid = 0; out_ready = 0;
    ALUOp = 0; Funct7 = 0; Funct3 = 0; SrcA = 0; SrcB = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_Result", Result, 32'd0);
    chk("rst_Operation", {27'b0, Operation}, 32'd0);
    chk("rst_Illegal", {31'b0, Illegal}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    mon_en = 1;

    issue(2'b10, 7'h00, 3'd0, 32'd5, 32'd7);
    issue(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4);
    issue(2'b10, 7'h1f, 3'd0, 32'd5, 32'd7);
    issue(2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(2'b10, 7'h01, 3'd4, 32'd7, 32'd0);
    issue(2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(2'b10, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(2'b10, 7'h01, 3'd5, 32'd100, 32'd7);
    issue(2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 7'h01, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b01, 7'h00, 3'd0, 32'd9, 32'd9);
    issue(2'b11, 7'h00, 3'd0, 32'd1, 32'hDEAD_BEEF);
    issue(2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1);
    drain();

    stall = 1;
    issue(2'b10, 7'h00, 3'd0, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    stall = 0;
    n = 0;
    while (out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

    rnd_bp = 1;
    repeat (60) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f7r = 7'h00;
        4, 5:       f7r = 7'h20;
        6, 7, 8:    f7r = 7'h01;
        default:    f7r = 7'($urandom);
      endcase
      issue(2'($urandom), f7r, 3'($urandom), rnd_operand(), rnd_operand());
    end
    rnd_bp = 0;
    drain();

    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'h01; SrcA = 32'd12345; SrcB = 32'd3;
`ifdef ALU_EXEC_DIV_EN
    Funct3 = 3'd5;
`else
    Funct3 = 3'd3;
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_Result", Result, 32'd0);
    chk("midrst_Operation", {27'b0, Operation}, 32'd0);
    chk("midrst_Illegal", {31'b0, Illegal}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1;
    issue(2'b10, 7'h00, 3'd0, 32'd1, 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Parametrised successor of the combinational ALU operation decoder. It accepts an instruction's ALUOp/Funct3/Funct7 plus two operands through a valid/ready handshake and decodes a 5-bit operation covering the base RV32I ALU set, JAL/LUI pass-through and the RV32M multiply/divide set. Base operations return in one cycle; M-extension operations run on an iterative shift-add / restoring-divide datapath. It sits in the execute stage and stalls the pipeline through `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `ALUOp`  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
- `Funct7`  in  7  instruction bits 31:25.
- `Funct3`  in  3  instruction bits 14:12.
- `SrcA`, `SrcB`  in  WIDTH  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `Result`  out  WIDTH  operation result.
- `Operation`  out  5  decoded op of the held result.
- `Illegal`  out  1  decode failed; Result forced to 0.

## Operation
- Decode, latched on accept (`in_valid && in_ready`):
  - ALUOp 00 → ADD 00000.
  - ALUOp 01 → BEQ 01010.
  - ALUOp 11 → PASSB 01011.
  - ALUOp 10, Funct7=0000000: f3 000 ADD 00000, 100 XOR 00010, 110 OR 00011, 111 AND 00100, 101 SRL 00101, 001 SLL 00110, 010 SLT 01000, 011 SLTU 01001.
  - ALUOp 10, Funct7=0100000: f3 000 SUB 00001, 101 SRA 00111.
  - ALUOp 10, Funct7=0000001: op = {2'b10, Funct3} (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - Any other combination → op 11111, `Illegal`=1. No latches; every path assigns.
- Shifts use `SrcB[$clog2(WIDTH)-1:0]`. SLT/SLTU/BEQ return 1 or 0 in bit 0. PASSB returns SrcB.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to RESP for base/illegal ops, MUL for 10000–10011, or DIV for 10100–10111.
  - MUL: WIDTH iterations on operand magnitudes, forming a 2·WIDTH product. Sign is fixed at the end. MUL returns the low half; the other variants return the high half.
  - DIV: WIDTH restoring iterations on magnitudes. Quotient sign = signA^signB; remainder sign = signA.
  - RESP: `out_valid`=1, holding Result/Operation/Illegal. Go to IDLE on `out_ready`.
- Divide boundary cases, decided at accept; they skip DIV and go straight to RESP:
  - Divide by zero: quotient all-ones, remainder = SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = −1): quotient = SrcA, remainder 0.
- Reset asserted in any state, including mid-iteration: next edge returns to IDLE with all outputs at their reset values; the partial result is discarded.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 after; `out_valid`=0, `Result`=0, `Operation`=0, `Illegal`=0.
- Base/illegal/boundary-divide ops: `out_valid` on the cycle after accept (latency 1).
- MUL/DIV: `out_valid` WIDTH+1 cycles after accept.
- Single outstanding operation:
  - `in_ready`=0 outside IDLE.
  - `in_valid` outside IDLE is ignored and must stay asserted by the source.
  - Outputs are stable while `out_valid && !out_ready`.
- Back-to-back: a new request is accepted no earlier than the cycle after the RESP handshake (throughput ≤ 1 op per 2 cycles).

## Configuration
- `ALU_EXEC_DIV_EN` defined: DIV/DIVU/REM/REMU implemented as above.
- Undefined: the divider is not built. Funct7=0000001 with f3 1xx decodes as illegal (11111, `Illegal`=1, latency 1). MUL ops are unaffected.

## Structure
- Package `alu_exec_pkg`:
  - `alu_op_e` enum, 5-bit, holding all codes above including ILLEGAL=11111.
  - `alu_state_e` enum: IDLE, MUL, DIV, RESP.
  - ALUOp and Funct7 constants.
- Sub-module `mdu_iter`: iterative mul/div datapath with an iteration counter, magnitude/sign handling, and `start`/`done`. The divider is guarded by the macro.
- Top level holds the decode, base ALU, FSM and output registers.

## Test plan
- Base ALU path:
  - ALUOp=10, f7=0000000, f3=000, A=5, B=7 → next cycle `out_valid`, Result=12, Operation=00000.
  - ALUOp=10, f7=0100000, f3=101, A=0x80000000, B=4 → Result=0xF8000000.
- Illegal decode: ALUOp=10, f7=0000000, f3=000 flipped to f7=0011111 → Illegal=1, Operation=11111, Result=0.
- MULH latency: MULH, A=0xFFFFFFFF (−1), B=2 → Result=0xFFFFFFFF exactly 33 cycles after accept; `in_ready`=0 throughout.
- Divide boundaries:
  - DIV, A=7, B=0 → Result=0xFFFFFFFF at latency 1.
  - REM, A=0x80000000, B=0xFFFFFFFF → Result=0.
  - DIV, A=−7, B=2 → −3; REM, A=−7, B=2 → −1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → Result stable, no new accept. Raise `out_ready` → IDLE next cycle.
- Reset mid-operation: `rst_n`=0 during cycle 10 of DIVU → next edge: `out_valid`=0, Result=0. After release, a new ADD 1+1 → 2.
